// File: rtl/wb_commit_if.sv
// rtl/wb_commit_if.sv - upstream, register-file, forwarding and trace signals of the commit stage
interface wb_commit_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 64
) ();
    // upstream (load/store stage) handshake and instruction fields
    logic              valid_last;
    logic              ready_last;
    logic [DATA_W-1:0] pc;
    logic              R_wen;
    logic [4:0]        rd;
    logic [DATA_W-1:0] rd_value;
    logic              mem_ren;
    logic [DATA_W-1:0] LSU_Rdata;
    logic              jump_flag;
    logic [3:0]        csr_wen;

    // register-file write port
    logic              rf_wen;
    logic [4:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    // forwarding tap
    logic              fwd_valid;
    logic [4:0]        fwd_rd;
    logic [DATA_W-1:0] fwd_data;

    // commit trace record
    logic              trace_valid;
    logic              trace_ready;
    logic [DATA_W-1:0] trace_pc;
    logic [4:0]        trace_rd;
    logic [DATA_W-1:0] trace_wdata;
    logic              trace_jump;
    logic [3:0]        trace_csr;

    logic [CNT_W-1:0]  instret;

    // master drives instructions in and consumes trace/writeback outputs
    modport master (
        output valid_last, pc, R_wen, rd, rd_value, mem_ren, LSU_Rdata, jump_flag, csr_wen,
        output trace_ready,
        input  ready_last,
        input  rf_wen, rf_waddr, rf_wdata,
        input  fwd_valid, fwd_rd, fwd_data,
        input  trace_valid, trace_pc, trace_rd, trace_wdata, trace_jump, trace_csr,
        input  instret
    );

    // slave is the commit stage itself
    modport slave (
        input  valid_last, pc, R_wen, rd, rd_value, mem_ren, LSU_Rdata, jump_flag, csr_wen,
        input  trace_ready,
        output ready_last,
        output rf_wen, rf_waddr, rf_wdata,
        output fwd_valid, fwd_rd, fwd_data,
        output trace_valid, trace_pc, trace_rd, trace_wdata, trace_jump, trace_csr,
        output instret
    );
endinterface

// File: rtl/wb_commit.sv
// rtl/wb_commit.sv - writeback/commit stage with one-entry holding register and retire counter
module wb_commit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 64
) (
    input  logic         clock,
    input  logic         reset,
    wb_commit_if.slave   bus
);

    // holding register: one retiring instruction waiting for the trace consumer
    logic              r_hold_v;
    logic              r_wen_q;
    logic [4:0]        r_rd;
    logic [DATA_W-1:0] r_wb_data;
    logic [DATA_W-1:0] r_pc;
    logic              r_jump;
    logic [3:0]        r_csr;
    logic [CNT_W-1:0]  r_instret;

    logic              w_ready;
    logic              w_capture;
    logic              w_commit;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_wen_in;

    // handshake decode: a commit frees the slot in the same cycle, so a new
    // instruction can be captured while the old one retires (no bubble)
    always_comb begin
        w_ready    = ~r_hold_v | bus.trace_ready;
        w_capture  = bus.valid_last & w_ready;
        w_commit   = r_hold_v & bus.trace_ready;
        w_sel_data = bus.mem_ren ? bus.LSU_Rdata : bus.rd_value;
        w_wen_in   = bus.R_wen & (bus.rd != 5'd0);
    end

    // holding-register valid flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_hold_v <= 1'b0;
        end else if (w_capture) begin
            r_hold_v <= 1'b1;
        end else if (w_commit) begin
            r_hold_v <= 1'b0;
        end
    end

    // captured instruction fields; load data is sampled only here
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wen_q   <= 1'b0;
            r_rd      <= 5'd0;
            r_wb_data <= '0;
            r_pc      <= '0;
            r_jump    <= 1'b0;
            r_csr     <= 4'd0;
        end else if (w_capture) begin
            r_wen_q   <= w_wen_in;
            r_rd      <= bus.rd;
            r_wb_data <= w_sel_data;
            r_pc      <= bus.pc;
            r_jump    <= bus.jump_flag;
            r_csr     <= bus.csr_wen;
        end
    end

    // retired-instruction counter, wraps naturally at 2^CNT_W
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_instret <= '0;
        end else if (w_commit) begin
            r_instret <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // output drive: register-file write happens only on the commit cycle,
    // trace hides rd/value of non-writing instructions
    always_comb begin
        bus.ready_last  = w_ready;
        bus.rf_wen      = w_commit & r_wen_q;
        bus.rf_waddr    = r_rd;
        bus.rf_wdata    = r_wb_data;
        bus.fwd_valid   = r_hold_v & r_wen_q;
        bus.fwd_rd      = r_rd;
        bus.fwd_data    = r_wb_data;
        bus.trace_valid = r_hold_v;
        bus.trace_pc    = r_pc;
        bus.trace_rd    = r_wen_q ? r_rd : 5'd0;
        bus.trace_wdata = r_wen_q ? r_wb_data : '0;
        bus.trace_jump  = r_jump;
        bus.trace_csr   = r_csr;
        bus.instret     = r_instret;
    end

endmodule
